// File: rtl/div_clk_monitor.sv
// Divided-clock self-check: measures period and high time of a divider output
// sampled on the fast clock, declares lock and flags ratio/duty/stall errors.
module div_clk_monitor #(
    parameter int unsigned DIV_RATIO = 2,
    parameter int unsigned TOL       = 0,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             div_clk_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             period_vld_o,
    output logic             lock_o,
    output logic             err_o
);

    localparam int unsigned EXT_W  = CNT_W + 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  HALF      = CNT_W'(DIV_RATIO / 2);
    localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(DIV_RATIO + TOL);
    localparam logic [CNT_W-1:0]  STALL_AT  = CNT_W'(DIV_RATIO + TOL + 1);
    localparam logic [EXT_W-1:0]  RATIO_X   = EXT_W'(DIV_RATIO);
    localparam logic [EXT_W-1:0]  TOL_X     = EXT_W'(TOL);
    localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [GOOD_W-1:0] LOCK_AT   = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_TRACK,
        S_LOCKED
    } state_e;

    state_e            r_state;
    logic              r_div_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_hi;
    logic [GOOD_W-1:0] r_good;

    logic             w_rise;
    logic             w_stall;
    logic             w_good;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_hi_nxt;

    assign w_rise = div_clk_i & ~r_div_q;

    // Saturating period and high-time counters, restarted on every rise
    assign w_cnt_nxt = w_rise                ? CNT_W'(1) :
                       (r_cnt == CNT_MAX)    ? r_cnt     : r_cnt + CNT_W'(1);
    assign w_hi_nxt  = w_rise                ? CNT_W'(1) :
                       !div_clk_i            ? r_hi      :
                       (r_hi == CNT_MAX)     ? r_hi      : r_hi + CNT_W'(1);

    // Lower bound computed one bit wider so DIV_RATIO-TOL never underflows
    assign w_good  = ((EXT_W'(r_cnt) + TOL_X) >= RATIO_X) &&
                     (r_cnt <= PER_MAX) && (r_hi == HALF);
    assign w_stall = ~w_rise && (r_cnt == STALL_AT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_div_q      <= 1'b0;
            r_cnt        <= '0;
            r_hi         <= '0;
            r_good       <= '0;
            period_o     <= '0;
            high_o       <= '0;
            period_vld_o <= 1'b0;
            lock_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            period_vld_o <= 1'b0;
            // A new error later in this block overrides the clear
            if (clr_i) begin
                err_o <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_div_q <= 1'b0;
                    r_cnt   <= '0;
                    r_hi    <= '0;
                    r_good  <= '0;
                    lock_o  <= 1'b0;
                    if (en_i) begin
                        r_state <= S_ARM;
                    end
                end
                default: begin
                    if (!en_i) begin
                        r_state <= S_IDLE;
                        lock_o  <= 1'b0;
                    end else begin
                        r_div_q <= div_clk_i;
                        r_cnt   <= w_cnt_nxt;
                        r_hi    <= w_hi_nxt;
                        if (r_state == S_ARM) begin
                            if (w_rise) begin
                                r_state <= S_TRACK;
                            end
                        end else if (w_rise || w_stall) begin
                            if (w_rise) begin
                                period_o     <= r_cnt;
                                high_o       <= r_hi;
                                period_vld_o <= 1'b1;
                            end
                            if (w_rise && w_good) begin
                                if (r_state == S_TRACK) begin
                                    if (r_good == LOCK_LAST) begin
                                        r_good  <= LOCK_AT;
                                        r_state <= S_LOCKED;
                                        lock_o  <= 1'b1;
                                    end else begin
                                        r_good <= r_good + GOOD_W'(1);
                                    end
                                end
                            end else begin
                                r_good <= '0;
                                if (r_state == S_LOCKED) begin
                                    r_state <= S_TRACK;
                                    lock_o  <= 1'b0;
                                    err_o   <= 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed vector bench for div_clk_monitor: three parameterisations driven
// from one table, plus hand-written reset and restart sequences.
module tb_div_clk_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       en_a, clr_a, div_a, vld_a, lock_a, err_a;
    logic [7:0] per_a, hi_a;
    logic       en_b, clr_b, div_b, vld_b, lock_b, err_b;
    logic [2:0] per_b, hi_b;
    logic       en_c, clr_c, div_c, vld_c, lock_c, err_c;
    logic [7:0] per_c, hi_c;

    div_clk_monitor #(.DIV_RATIO(2), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .clr_i(clr_a), .div_clk_i(div_a),
        .period_o(per_a), .high_o(hi_a), .period_vld_o(vld_a), .lock_o(lock_a), .err_o(err_a));

    div_clk_monitor #(.DIV_RATIO(4), .TOL(0), .LOCK_CNT(4), .CNT_W(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .clr_i(clr_b), .div_clk_i(div_b),
        .period_o(per_b), .high_o(hi_b), .period_vld_o(vld_b), .lock_o(lock_b), .err_o(err_b));

    div_clk_monitor #(.DIV_RATIO(4), .TOL(1), .LOCK_CNT(4), .CNT_W(8)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_c), .clr_i(clr_c), .div_clk_i(div_c),
        .period_o(per_c), .high_o(hi_c), .period_vld_o(vld_c), .lock_o(lock_c), .err_o(err_c));

    typedef struct {
        int unsigned dut;
        logic        en;
        logic        clr;
        logic        div;
        logic [7:0]  vld;
        logic [7:0]  per;
        logic [7:0]  hi;
        logic [7:0]  lock;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void v(int d, int en, int clr, int div,
                              int vld, int per, int hi, int lock, int err);
        vec_t x;
        x.dut  = d;
        x.en   = 1'(en);
        x.clr  = 1'(clr);
        x.div  = 1'(div);
        x.vld  = 8'(vld);
        x.per  = 8'(per);
        x.hi   = 8'(hi);
        x.lock = 8'(lock);
        x.err  = 8'(err);
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic drive(input int unsigned d, input logic en, input logic clr, input logic div);
        case (d)
            0: begin en_a = en; clr_a = clr; div_a = div; end
            1: begin en_b = en; clr_b = clr; div_b = div; end
            default: begin en_c = en; clr_c = clr; div_c = div; end
        endcase
    endtask

    task automatic sample(input int unsigned d, output logic [7:0] vld, output logic [7:0] per,
                          output logic [7:0] hi, output logic [7:0] lock, output logic [7:0] err);
        case (d)
            0: begin
                vld = {7'd0, vld_a}; per = per_a; hi = hi_a;
                lock = {7'd0, lock_a}; err = {7'd0, err_a};
            end
            1: begin
                vld = {7'd0, vld_b}; per = {5'd0, per_b}; hi = {5'd0, hi_b};
                lock = {7'd0, lock_b}; err = {7'd0, err_b};
            end
            default: begin
                vld = {7'd0, vld_c}; per = per_c; hi = hi_c;
                lock = {7'd0, lock_c}; err = {7'd0, err_c};
            end
        endcase
    endtask

    task automatic check_all(input int unsigned d, input int idx, input logic [7:0] e_vld,
                             input logic [7:0] e_per, input logic [7:0] e_hi,
                             input logic [7:0] e_lock, input logic [7:0] e_err);
        logic [7:0] g_vld, g_per, g_hi, g_lock, g_err;
        sample(d, g_vld, g_per, g_hi, g_lock, g_err);
        check($sformatf("d%0d.period_vld", d), idx, g_vld,  e_vld);
        check($sformatf("d%0d.period",     d), idx, g_per,  e_per);
        check($sformatf("d%0d.high",       d), idx, g_hi,   e_hi);
        check($sformatf("d%0d.lock",       d), idx, g_lock, e_lock);
        check($sformatf("d%0d.err",        d), idx, g_err,  e_err);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // DUT 1: ratio 4, CNT_W=3, duty 3/4 -> always bad; then a long low saturates at 7
        v(1,1,0,0, 0,0,0,0,0);  v(1,1,0,1, 0,0,0,0,0);  v(1,1,0,1, 0,0,0,0,0);
        v(1,1,0,1, 0,0,0,0,0);  v(1,1,0,0, 0,0,0,0,0);  v(1,1,0,1, 1,4,3,0,0);
        for (int k = 0; k < 4; k++) begin
            v(1,1,0,1, 0,4,3,0,0);  v(1,1,0,1, 0,4,3,0,0);
            v(1,1,0,0, 0,4,3,0,0);  v(1,1,0,1, 1,4,3,0,0);
        end
        for (int k = 0; k < 7; k++) v(1,1,0,0, 0,4,3,0,0);
        v(1,1,0,1, 1,7,1,0,0);

        // DUT 2: ratio 4, TOL 1: periods 4,5,3,4 lock, then a period of 6 errors
        v(2,1,0,0, 0,0,0,0,0);  v(2,1,0,1, 0,0,0,0,0);  v(2,1,0,1, 0,0,0,0,0);
        v(2,1,0,0, 0,0,0,0,0);  v(2,1,0,0, 0,0,0,0,0);  v(2,1,0,1, 1,4,2,0,0);
        v(2,1,0,1, 0,4,2,0,0);  v(2,1,0,0, 0,4,2,0,0);  v(2,1,0,0, 0,4,2,0,0);
        v(2,1,0,0, 0,4,2,0,0);  v(2,1,0,1, 1,5,2,0,0);  v(2,1,0,1, 0,5,2,0,0);
        v(2,1,0,0, 0,5,2,0,0);  v(2,1,0,1, 1,3,2,0,0);  v(2,1,0,1, 0,3,2,0,0);
        v(2,1,0,0, 0,3,2,0,0);  v(2,1,0,0, 0,3,2,0,0);  v(2,1,0,1, 1,4,2,1,0);
        v(2,1,0,1, 0,4,2,1,0);  v(2,1,0,0, 0,4,2,1,0);  v(2,1,0,0, 0,4,2,1,0);
        v(2,1,0,0, 0,4,2,1,0);  v(2,1,0,0, 0,4,2,1,0);  v(2,1,0,1, 1,6,2,0,1);

        // DUT 0: true divide-by-2, lock on 5th rise
        v(0,1,0,0, 0,0,0,0,0);  v(0,1,0,1, 0,0,0,0,0);  v(0,1,0,0, 0,0,0,0,0);
        v(0,1,0,1, 1,2,1,0,0);  v(0,1,0,0, 0,2,1,0,0);  v(0,1,0,1, 1,2,1,0,0);
        v(0,1,0,0, 0,2,1,0,0);  v(0,1,0,1, 1,2,1,0,0);  v(0,1,0,0, 0,2,1,0,0);
        v(0,1,0,1, 1,2,1,1,0);
        // stall while locked, resume and relock with err sticky, then clear
        v(0,1,0,0, 0,2,1,1,0);  v(0,1,0,0, 0,2,1,1,0);  v(0,1,0,0, 0,2,1,0,1);
        v(0,1,0,0, 0,2,1,0,1);  v(0,1,0,1, 1,5,1,0,1);  v(0,1,0,0, 0,5,1,0,1);
        v(0,1,0,1, 1,2,1,0,1);  v(0,1,0,0, 0,2,1,0,1);  v(0,1,0,1, 1,2,1,0,1);
        v(0,1,0,0, 0,2,1,0,1);  v(0,1,0,1, 1,2,1,0,1);  v(0,1,0,0, 0,2,1,0,1);
        v(0,1,0,1, 1,2,1,1,1);  v(0,1,1,0, 0,2,1,1,0);  v(0,1,0,1, 1,2,1,1,0);
        // stall with clr_i in the same cycle: error wins
        v(0,1,0,0, 0,2,1,1,0);  v(0,1,0,0, 0,2,1,1,0);  v(0,1,1,0, 0,2,1,0,1);
        v(0,1,0,1, 1,4,1,0,1);  v(0,1,0,0, 0,4,1,0,1);  v(0,1,0,1, 1,2,1,0,1);
        v(0,1,0,0, 0,2,1,0,1);  v(0,1,0,1, 1,2,1,0,1);  v(0,1,0,0, 0,2,1,0,1);
        v(0,1,0,1, 1,2,1,0,1);  v(0,1,0,0, 0,2,1,0,1);  v(0,1,0,1, 1,2,1,1,1);
        // drop en_i while locked; re-enable with div already high
        v(0,0,0,0, 0,2,1,0,1);  v(0,1,0,1, 0,2,1,0,1);  v(0,1,0,1, 0,2,1,0,1);
        v(0,1,0,0, 0,2,1,0,1);  v(0,1,0,1, 1,2,1,0,1);  v(0,1,0,0, 0,2,1,0,1);
        v(0,1,0,1, 1,2,1,0,1);  v(0,1,0,0, 0,2,1,0,1);  v(0,1,0,1, 1,2,1,0,1);
        v(0,1,0,0, 0,2,1,0,1);  v(0,1,0,1, 1,2,1,1,1);

        rst_n = 1'b0;
        en_a = 1'b0; clr_a = 1'b0; div_a = 1'b0;
        en_b = 1'b0; clr_b = 1'b0; div_b = 1'b0;
        en_c = 1'b0; clr_c = 1'b0; div_c = 1'b0;
        step;
        step;
        for (int d = 0; d < 3; d++) check_all(d, -1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].dut, vecs[i].en, vecs[i].clr, vecs[i].div);
            step;
            check_all(vecs[i].dut, i, vecs[i].vld, vecs[i].per, vecs[i].hi,
                      vecs[i].lock, vecs[i].err);
        end

        // asynchronous reset mid-LOCKED clears everything without a clock edge
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check_all(d, 1000, 0, 0, 0, 0, 0);
        step;
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0);
        step;
        check_all(0, 1001, 0, 0, 0, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b1);
        step;
        check_all(0, 1002, 0, 0, 0, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b0);
        step;
        check_all(0, 1003, 0, 0, 0, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b1);
        step;
        check_all(0, 1004, 1, 2, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
